mem_responder: RTL and testbench

Memory-side responder for the multicycle CPU's memory port. It accepts one read or write request at a time from the datapath and services it against an internal word-addressed storage array. It inserts a programmable number of wait states, then returns a one-cycle completion strobe with read data or an error flag. It replaces the zero-latency memory model so that controller wait-state handling can be exercised.

---
 rtl/mem_pkg.sv | 33 +++
 rtl/mem_array.sv | 26 ++
 rtl/mem_responder.sv | 107 ++++++++++
 tb/tb_mem_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings and default sizes for the memory-side responder.
// FSM states, request op codes and a helper that classifies a captured request.
package mem_pkg;

   localparam int DEF_DATA_W      = 32;
   localparam int DEF_ADDR_W      = 32;
   localparam int DEF_DEPTH       = 256;
   localparam int DEF_WAIT_CYCLES = 2;
   localparam int CNT_W           = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      OP_RD  = 2'd0,
      OP_WR  = 2'd1,
      OP_BAD = 2'd2
   } op_t;

   // Read and write asserted together is a protocol error, not a priority choice.
   function automatic op_t decode_op(input logic rd, input logic wr);
      if (rd && wr)
         return OP_BAD;
      else if (wr)
         return OP_WR;
      else
         return OP_RD;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: synchronous write, combinational read, contents not reset.
// Shares one index between read and write since only one access is in flight.
module mem_array
   import mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int IDX_W  = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] store [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         store[idx] <= wdata;
   end

   assign rdata = store[idx];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: captures one request, waits WAIT_CYCLES, then strobes
// mem_ready for one cycle with read data or mem_err.
//
// Handshake: memRead/memWrite are levels sampled only in IDLE; the initiator drops
// them by the mem_ready cycle, and anything seen while busy is dropped, never queued.
module mem_responder
   import mem_pkg::*;
#(
   parameter int DATA_W      = DEF_DATA_W,
   parameter int ADDR_W      = DEF_ADDR_W,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              mem_ready,
   output logic              mem_err,
   output logic              busy
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   generate
      if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
         $error("mem_responder: WAIT_CYCLES must be within 0..15");
      end
   endgenerate

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   op_t               op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata;
   logic              req;
   logic              in_range;
   logic              fire;
   logic              wr_en;

   assign req      = memRead | memWrite;
   // Full-width compare so high address bits cannot alias into the array.
   assign in_range = addr_q < ADDR_W'(DEPTH);
   assign fire     = (state == ACCESS) && (cnt == '0);
   assign wr_en    = fire && (op_q == OP_WR) && in_range;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = ACCESS;
         ACCESS:  if (cnt == '0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         op_q     <= OP_RD;
         addr_q   <= '0;
         wdata_q  <= '0;
         data_out <= '0;
      end else begin
         if (state == IDLE && req) begin
            cnt     <= CNT_W'(WAIT_CYCLES);
            op_q    <= decode_op(memRead, memWrite);
            addr_q  <= address;
            wdata_q <= data_in;
         end else if (state == ACCESS && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
         end
         // OP_BAD and writes leave data_out alone; out-of-range reads return zero.
         if (fire && op_q == OP_RD)
            data_out <= in_range ? rdata : '0;
      end
   end

   assign mem_ready = (state == RESP);
   assign mem_err   = mem_ready && ((op_q == OP_BAD) || !in_range);
   assign busy      = (state != IDLE);

   mem_array #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk   (clk),
      .we    (wr_en),
      .idx   (addr_q[IDX_W-1:0]),
      .wdata (wdata_q),
      .rdata (rdata)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with two wait states, one with none,
// sharing clock and reset; a reference array and expected-response queue per request.
module tb_mem_responder;

   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_read  [2];
   logic          mem_write [2];
   logic [AW-1:0] address   [2];
   logic [DW-1:0] data_in   [2];
   logic [DW-1:0] data_out  [2];
   logic          mem_ready [2];
   logic          mem_err   [2];
   logic          busy      [2];

   int            wait_of   [2];
   logic [DW:0]   exp_q[$];
   logic [DW-1:0] model     [2][DEPTH];
   bit            written   [2][DEPTH];
   logic [DW-1:0] last_dout [2];
   int            vectors = 0;
   int            errors  = 0;

   always #5 clk = ~clk;

   mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_w2 (
      .clk(clk), .rst(rst), .memRead(mem_read[0]), .memWrite(mem_write[0]),
      .address(address[0]), .data_in(data_in[0]), .data_out(data_out[0]),
      .mem_ready(mem_ready[0]), .mem_err(mem_err[0]), .busy(busy[0])
   );

   mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .rst(rst), .memRead(mem_read[1]), .memWrite(mem_write[1]),
      .address(address[1]), .data_in(data_in[1]), .data_out(data_out[1]),
      .mem_ready(mem_ready[1]), .mem_err(mem_err[1]), .busy(busy[1])
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Issue one request from a negedge; returns at the negedge after the strobe.
   task automatic req(input int s, input bit rd, input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input bit poke_resp);
      logic [DW:0] exp;
      logic [DW:0] got;
      bit          seen;
      int          lat;
      if (rd && wr)
         exp = {1'b1, last_dout[s]};
      else if (a >= AW'(DEPTH))
         exp = {1'b1, (rd ? {DW{1'b0}} : last_dout[s])};
      else if (rd)
         exp = {1'b0, model[s][a[7:0]]};
      else begin
         exp = {1'b0, last_dout[s]};
         model[s][a[7:0]]   = d;
         written[s][a[7:0]] = 1'b1;
      end
      last_dout[s] = exp[DW-1:0];
      exp_q.push_back(exp);

      mem_read[s]  = rd;
      mem_write[s] = wr;
      address[s]   = a;
      data_in[s]   = d;
      @(posedge clk);
      #1;
      check_eq("busy_after_capture", 64'(busy[s]), 64'd1);
      mem_read[s]  = 1'b0;
      mem_write[s] = 1'b0;
      address[s]   = a;
      data_in[s]   = $urandom;

      seen = 1'b0;
      lat  = 0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         @(negedge clk);
         if (mem_ready[s]) begin
            seen = 1'b1;
            lat  = k - 1;
         end
      end
      exp = exp_q.pop_front();
      if (!seen) begin
         check_eq("ready_timeout", 64'd0, 64'd1);
         return;
      end
      check_eq("ready_latency", 64'(lat), 64'(wait_of[s] + 1));
      got = {mem_err[s], data_out[s]};
      check_eq("err_flag", 64'(got[DW]), 64'(exp[DW]));
      check_eq("read_data", 64'(got[DW-1:0]), 64'(exp[DW-1:0]));
      if (poke_resp) begin
         mem_read[s] = 1'b1;
         address[s]  = 32'd1;
      end
      @(negedge clk);
      check_eq("ready_one_cycle", 64'(mem_ready[s]), 64'd0);
      if (poke_resp) begin
         check_eq("resp_req_ignored", 64'(busy[s]), 64'd0);
         mem_read[s] = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      int            s;
      bit            flag;

      wait_of[0] = 2;
      wait_of[1] = 0;
      for (int i = 0; i < 2; i++) begin
         mem_read[i]  = 1'b0;
         mem_write[i] = 1'b0;
         address[i]   = '0;
         data_in[i]   = '0;
         last_dout[i] = '0;
         for (int j = 0; j < DEPTH; j++) begin
            model[i][j]   = '0;
            written[i][j] = 1'b0;
         end
      end

      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check_eq("rst_data_out", 64'(data_out[i]), 64'd0);
         check_eq("rst_ready", 64'(mem_ready[i]), 64'd0);
         check_eq("rst_err", 64'(mem_err[i]), 64'd0);
         check_eq("rst_busy", 64'(busy[i]), 64'd0);
      end
      rst = 1'b0;
      @(negedge clk);

      // Preload and timed read with two wait states.
      req(0, 0, 1, 32'd5, 32'hDEADBEEF, 0);
      req(0, 1, 0, 32'd5, 32'h0, 0);
      // Write/read-back; data_in is scrambled right after capture inside req.
      req(0, 0, 1, 32'd10, 32'h12345678, 0);
      req(0, 1, 0, 32'd10, 32'h0, 0);
      // Out-of-range read, and a high-bit address that must not alias onto word 5.
      req(0, 1, 0, 32'd256, 32'h0, 0);
      req(0, 0, 1, 32'h8000_0005, 32'hFFFF_0000, 0);
      req(0, 1, 0, 32'd5, 32'h0, 0);
      // Read+write together at address 3.
      req(0, 0, 1, 32'd3, 32'h3333_3333, 0);
      req(0, 1, 0, 32'd10, 32'h0, 0);
      req(0, 1, 1, 32'd3, 32'hBAD0_BAD0, 0);
      req(0, 1, 0, 32'd3, 32'h0, 0);

      // Reset during ACCESS of a pending write.
      req(0, 0, 1, 32'd7, 32'h0BAD_F00D, 0);
      req(0, 1, 0, 32'd10, 32'h0, 0);
      mem_write[0] = 1'b1;
      address[0]   = 32'd7;
      data_in[0]   = 32'hA5A5A5A5;
      @(posedge clk);
      #1;
      mem_write[0] = 1'b0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check_eq("midrst_data_out", 64'(data_out[0]), 64'd0);
      check_eq("midrst_ready", 64'(mem_ready[0]), 64'd0);
      check_eq("midrst_err", 64'(mem_err[0]), 64'd0);
      check_eq("midrst_busy", 64'(busy[0]), 64'd0);
      last_dout[0] = '0;
      last_dout[1] = '0;
      @(negedge clk);
      rst  = 1'b0;
      flag = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (mem_ready[0]) flag = 1'b1;
      end
      check_eq("no_ready_after_abort", 64'(flag), 64'd0);
      req(0, 1, 0, 32'd7, 32'h0, 0);

      // Zero wait states, back-to-back, with a request poked during RESP.
      req(1, 0, 1, 32'd1, 32'h1111_0001, 0);
      req(1, 0, 1, 32'd2, 32'h2222_0002, 0);
      req(1, 1, 0, 32'd1, 32'h0, 1);
      req(1, 1, 0, 32'd2, 32'h0, 0);
      req(1, 1, 0, 32'd300, 32'h0, 0);

      // Randomised mix on both instances.
      for (int n = 0; n < 24; n++) begin
         s = $urandom_range(0, 1);
         a = AW'($urandom_range(0, 31));
         d = $urandom;
         if (written[s][a[7:0]] && $urandom_range(0, 1) == 1)
            req(s, 1, 0, a, d, 0);
         else if ($urandom_range(0, 7) == 0)
            req(s, 1, 1, a, d, 0);
         else
            req(s, 0, 1, a, d, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
